// File: rtl/ikaopm_dac_pkg.sv
// Shared definitions for the floating-point DAC model.
// Contents: receive FSM state type, frame geometry constants, mantissa offset.
package ikaopm_dac_pkg;

  localparam int unsigned FRAME_LEN = 16;  // ticks per channel frame
  localparam int unsigned DATA_BITS = 13;  // 9 magnitude + 1 sign + 3 exponent

  // Offset-binary to two's complement: flipping the top bit of {s, m}.
  localparam logic [9:0] MANT_OFFSET = 10'h200;

  typedef enum logic [1:0] {
    StIdle,
    StRecvR,
    StRecvL
  } dac_state_e;

endpackage

// File: rtl/ikaopm_dac_fp_decode.sv
// Combinational floating-point to linear decoder.
// Ports:
//   sign_i   - sign bit s (1 = positive)
//   mant_i   - 9-bit mantissa magnitude m
//   expo_i   - 3-bit exponent e (0 = silence)
//   linear_o - 16-bit two's complement linear sample
module ikaopm_dac_fp_decode
  import ikaopm_dac_pkg::*;
(
  input  logic       sign_i,
  input  logic [8:0] mant_i,
  input  logic [2:0] expo_i,
  output logic [15:0] linear_o
);

  logic        [9:0]  v10;
  logic signed [15:0] v16;
  logic        [2:0]  shamt;

  always_comb begin
    v10   = {sign_i, mant_i} ^ MANT_OFFSET;
    v16   = {{6{v10[9]}}, v10};
    shamt = expo_i - 3'd1;
    // Largest shift is 6, so a 10-bit value never overflows 16 bits.
    linear_o = (expo_i == 3'd0) ? 16'h0000 : (v16 <<< shamt);
  end

endmodule

// File: rtl/ikaopm_dac_emu.sv
// Emulator model of the companion floating-point DAC.
// Deserializes the LSB-first sound stream framed by SH1 (right) / SH2 (left),
// decodes each 13-bit float into a 16-bit linear sample and pulses a VALID.
// Ports:
//   i_EMUCLK      - master clock
//   i_MRST        - asynchronous active-high reset
//   i_phi1_NCEN_n - active-low tick enable
//   i_SO          - serial data
//   i_SH1/i_SH2   - right/left frame strobes
//   o_R_PO/o_L_PO - right/left samples
//   o_R_VALID/o_L_VALID - one-tick update pulses
//   o_FRAME_ERR   - one-tick pulse on short or colliding frames
// Build option: define IKAOPM_DAC_LOWPASS_EN to average each new sample with
// the previous output of the same channel.
module ikaopm_dac_emu
  import ikaopm_dac_pkg::*;
(
  input  logic        i_EMUCLK,
  input  logic        i_MRST,
  input  logic        i_phi1_NCEN_n,
  input  logic        i_SO,
  input  logic        i_SH1,
  input  logic        i_SH2,
  output logic [15:0] o_R_PO,
  output logic [15:0] o_L_PO,
  output logic        o_R_VALID,
  output logic        o_L_VALID,
  output logic        o_FRAME_ERR
);

  localparam logic [4:0] CntMax   = 5'(FRAME_LEN);
  localparam logic [4:0] DataBits = 5'(DATA_BITS);

  dac_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [12:0] shreg_q, shreg_d;
  logic        sh1_z_q, sh1_z_d, sh2_z_q, sh2_z_d;
  logic [15:0] r_po_q, r_po_d, l_po_q, l_po_d;
  logic        r_valid_q, r_valid_d, l_valid_q, l_valid_d;
  logic        frame_err_q, frame_err_d;

  logic        sh1_rise, sh2_rise;
  logic        recv_r, own_strobe, other_rise;
  logic [15:0] linear, r_new, l_new;

  // One decoder serves both channels: frames never overlap.
  ikaopm_dac_fp_decode u_decode (
    .sign_i   (shreg_q[9]),
    .mant_i   (shreg_q[8:0]),
    .expo_i   (shreg_q[12:10]),
    .linear_o (linear)
  );

`ifdef IKAOPM_DAC_LOWPASS_EN
  logic [16:0] r_sum, l_sum;
  assign r_sum = {r_po_q[15], r_po_q} + {linear[15], linear};
  assign l_sum = {l_po_q[15], l_po_q} + {linear[15], linear};
  assign r_new = r_sum[16:1];
  assign l_new = l_sum[16:1];
`else
  assign r_new = linear;
  assign l_new = linear;
`endif

  assign sh1_rise   = i_SH1 & ~sh1_z_q;
  assign sh2_rise   = i_SH2 & ~sh2_z_q;
  assign recv_r     = (state_q == StRecvR);
  assign own_strobe = recv_r ? i_SH1 : i_SH2;
  assign other_rise = recv_r ? sh2_rise : sh1_rise;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    sh1_z_d     = i_SH1;
    sh2_z_d     = i_SH2;
    r_po_d      = r_po_q;
    l_po_d      = l_po_q;
    r_valid_d   = 1'b0;
    l_valid_d   = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sh1_rise && sh2_rise) begin
          frame_err_d = 1'b1;
        end else if ((sh1_rise && !i_SH2) || (sh2_rise && !i_SH1)) begin
          state_d = sh1_rise ? StRecvR : StRecvL;
          cnt_d   = 5'd1;
          shreg_d = {12'h000, i_SO};
        end
      end
      StRecvR, StRecvL: begin
        if (other_rise) begin
          frame_err_d = 1'b1;
          state_d     = StIdle;
        end else if (own_strobe) begin
          if (cnt_q < DataBits) shreg_d[cnt_q[3:0]] = i_SO;
          if (cnt_q < CntMax) cnt_d = cnt_q + 5'd1;
        end else begin
          state_d = StIdle;
          if (cnt_q >= DataBits) begin
            if (recv_r) begin
              r_po_d    = r_new;
              r_valid_d = 1'b1;
            end else begin
              l_po_d    = l_new;
              l_valid_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
    if (i_MRST) begin
      state_q     <= StIdle;
      cnt_q       <= 5'd0;
      shreg_q     <= 13'h0000;
      sh1_z_q     <= 1'b0;
      sh2_z_q     <= 1'b0;
      r_po_q      <= 16'h0000;
      l_po_q      <= 16'h0000;
      r_valid_q   <= 1'b0;
      l_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else if (!i_phi1_NCEN_n) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      sh1_z_q     <= sh1_z_d;
      sh2_z_q     <= sh2_z_d;
      r_po_q      <= r_po_d;
      l_po_q      <= l_po_d;
      r_valid_q   <= r_valid_d;
      l_valid_q   <= l_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign o_R_PO      = r_po_q;
  assign o_L_PO      = l_po_q;
  assign o_R_VALID   = r_valid_q;
  assign o_L_VALID   = l_valid_q;
  assign o_FRAME_ERR = frame_err_q;

endmodule

// File: doc/ikaopm_dac_emu.md
Name: ikaopm_dac_emu

Overview:
- Digital model of the companion floating-point DAC, placed directly downstream of the R/L accumulator/serializer stage.
- Consumes the serial sound stream plus per-channel sample-hold strobes and deserializes each 16-tick frame.
- Decodes the 10-bit offset-binary mantissa and 3-bit exponent into 16-bit signed linear samples, with valid pulses per channel.
- Feeds the emulator audio path (resampler/mixer).

Parameters:
- FRAME_LEN, 16, ticks per channel frame while a strobe is high.
- DATA_BITS, 13, meaningful bits per frame (9 magnitude + 1 sign + 3 exponent).

Ports:
- i_EMUCLK  in  1  emulator master clock (only clock)
- i_MRST  in  1  asynchronous, active-high reset
- i_phi1_NCEN_n  in  1  active-low tick enable; all state advances only on enabled ticks
- i_SO  in  1  serial sound data, LSB first
- i_SH1  in  1  right-channel frame strobe, high for the whole right frame
- i_SH2  in  1  left-channel frame strobe, high for the whole left frame
- o_R_PO  out  16  right sample, two's complement
- o_L_PO  out  16  left sample, two's complement
- o_R_VALID  out  1  one-tick pulse when o_R_PO updates
- o_L_VALID  out  1  one-tick pulse when o_L_PO updates
- o_FRAME_ERR  out  1  one-tick pulse on a malformed frame

Behaviour:
- Reset (async, i_MRST=1): all outputs 0, FSM IDLE, bit counter 0, shift register 0, strobe history 0.
- Tick = rising i_EMUCLK edge with i_phi1_NCEN_n=0. No state changes on other edges.
- Frame bit order within the 16 ticks:
  - bits 0-8: mantissa magnitude m[8:0]
  - bit 9: sign s (1 = positive)
  - bits 10-12: exponent e[2:0]
  - bits 13-15: don't care
- FSM states: IDLE, RECV_R, RECV_L.
  - Rise detection uses registered sh1_z/sh2_z.
  - IDLE -> RECV_R on i_SH1 rise with i_SH2=0.
  - IDLE -> RECV_L on i_SH2 rise with i_SH1=0.
  - On entry, bit counter = 1 and the tick's i_SO is captured as bit 0.
- While receiving:
  - Each tick with the strobe still high: if counter < 13, shift i_SO into bit[counter]; counter saturates at 16.
  - Strobe fall with counter >= 13: decode, latch the channel output one tick later, pulse its VALID for exactly one tick, go to IDLE.
  - Strobe fall with counter < 13: pulse o_FRAME_ERR, keep the channel output unchanged, go to IDLE.
- Decode:
  - v10 = {s, m} XOR 10'h200, read as signed 10-bit.
  - e = 0: linear = 0.
  - e = 1..7: linear = sign-extended v10 <<< (e-1), 16-bit result (no overflow possible).
- Simultaneous or overlapping strobes:
  - Both strobes rise on the same tick: o_FRAME_ERR, stay IDLE.
  - Other strobe rises during a receive: abort, o_FRAME_ERR, go IDLE. No new frame starts until a clean rise.
- Latency: strobe-fall tick -> VALID and data one tick later. VALID is never asserted on both channels in the same tick.
- Reset mid-frame: partial frame discarded, outputs forced to 0.

Optional Feature:
- Macro: IKAOPM_DAC_LOWPASS_EN.
- Defined: the latched output = (previous output + new linear) >>> 1, using a 17-bit intermediate sum and arithmetic shift. Applies per channel; reset clears the history. VALID timing is unchanged.
- Undefined: the output equals the new linear value directly.

Decomposition:
- Package ikaopm_dac_pkg holds:
  - FSM state typedef (IDLE/RECV_R/RECV_L)
  - FRAME_LEN/DATA_BITS constants
  - mantissa offset constant 10'h200
- Sub-module ikaopm_dac_fp_decode: combinational {s, m, e} -> 16-bit linear. Instantiated once; the 13-bit shift register is shared because frames never overlap.

Test Plan:
- Right frame s=1, m=0x1FF, e=7 -> o_R_PO=16'h7FC0, o_R_VALID pulses once, one tick after SH1 falls.
- Left frame s=0, m=0x000, e=7 -> o_L_PO=16'h8000; left frame s=1, m=0x001, e=1 -> o_L_PO=16'h0001.
- Frame with e=0, s=1, m=0x155 -> output 16'h0000 with VALID; s=0, m=0x1FF, e=3 -> v10=-1, output 16'hFFFC.
- SH1 held high only 10 ticks -> o_FRAME_ERR one pulse, o_R_PO keeps its previous value, no VALID.
- SH2 rises while SH1 frame is at bit 6 -> o_FRAME_ERR, neither output changes; next clean SH1 frame decodes normally.
- Assert i_MRST at bit 8 of a frame -> all outputs 0 immediately; a subsequent full frame decodes correctly. With IKAOPM_DAC_LOWPASS_EN: two frames 16'h7FC0 then 16'h0000 -> outputs 16'h3FE0, then 16'h1FF0.
